// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for the VGA raster generator.
//   - 640x480@60 default porch/sync/active values (pixels and lines)
//   - H_TOTAL / V_TOTAL for the default mode
//   - sync polarity constants
package vga_pkg;

    // 640x480@60, 25.175 MHz nominal pixel rate
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// timing_axis_counter: one raster axis (horizontal or vertical).
//   Counts 0..TOTAL-1 on each `step`, ordered active / front porch / sync /
//   back porch. Reset lands on the last back-porch position so the first
//   step produces count 0.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   step        - advance one position
//   count       - current position (registered)
//   wrap        - this step takes count from TOTAL-1 back to 0 (combinational,
//                 used to step the next axis)
//   active      - count is inside the active region (registered)
//   sync_n      - low while count is inside the sync region (registered)
module timing_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync_n
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END   = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG  = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END  = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q, count_d;
    logic         active_q, active_d;
    logic         sync_n_q, sync_n_d;

    assign wrap = step && (count_q == LAST);

    // Flags are decoded from the next count so they change on the same edge
    // as the count itself.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        sync_n_d = sync_n_q;
        if (step) begin
            count_d  = wrap ? '0 : count_q + 1'b1;
            active_d = (count_d < ACT_END);
            sync_n_d = !((count_d >= SYNC_BEG) && (count_d < SYNC_END));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= LAST;
            active_q <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count  = count_q;
    assign active = active_q;
    assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   A clock-enable divider produces one pixel step every CLK_DIV clocks; two
//   axis counters track (x,y). Every output is a flop (or a constant-polarity
//   inversion / AND of flops), so no input reaches an output combinationally.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   en           - run; low freezes divider, counters and outputs
//   pix_ce       - one-clock pulse in the cycle after the outputs advance
//   h_sync       - horizontal sync, HS_POL while asserted
//   v_sync       - vertical sync, VS_POL while asserted
//   in_display   - current pixel is in the active area
//   x, y         - current raster position (not masked in blanking)
//   line_start   - current pixel has x==0
//   frame_start  - current pixel has x==0 and y==0
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = POL_LOW,
    parameter logic VS_POL   = POL_LOW,
    parameter int   CLK_DIV  = 2,
    parameter int   X_W      = 10,
    parameter int   Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic           pix_ce,
    output logic           h_sync,
    output logic           v_sync,
    output logic           in_display,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             step;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active;
    logic             h_sync_n, v_sync_n;

    // `en` gates the step itself, so dropping it on a step edge suppresses it.
    assign step = en && (div_q == DIV_LAST);

    always_comb begin
        div_d         = div_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        pix_ce_d      = step;
        if (en) begin
            div_d = step ? '0 : div_q + 1'b1;
        end
        if (step) begin
            line_start_d  = h_wrap;
            frame_start_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    timing_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .count  (x),
        .wrap   (h_wrap),
        .active (h_active),
        .sync_n (h_sync_n)
    );

    // Vertical axis steps on the horizontal wrap, so v_sync changes on whole
    // lines together with x returning to 0.
    timing_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (h_wrap),
        .count  (y),
        .wrap   (v_wrap),
        .active (v_active),
        .sync_n (v_sync_n)
    );

    assign pix_ce      = pix_ce_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign in_display  = h_active && v_active;
    assign h_sync      = HS_POL ? ~h_sync_n : h_sync_n;
    assign v_sync      = VS_POL ? ~v_sync_n : v_sync_n;

endmodule
